// File: rtl/led_ctrl_pkg.sv
// Shared types and constants for the front-panel LED step controller.
package led_ctrl_pkg;

    typedef enum logic [1:0] {RUN, PAUSE, STEP} step_state_t;

    // One decoded command per cycle, already resolved by button priority.
    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_DEFAULT,
        CMD_PAUSE,
        CMD_SINGLE,
        CMD_FASTER,
        CMD_SLOWER
    } cmd_t;

    localparam int NUM_SPEEDS = 5;
    localparam logic [2:0] MAX_IDX = 3'd4;

    localparam int BTN_SLOWER  = 0;
    localparam int BTN_FASTER  = 1;
    localparam int BTN_PAUSE   = 2;
    localparam int BTN_SINGLE  = 3;
    localparam int BTN_DEFAULT = 4;

    // Step period for a speed level: slowest period minus one step per level.
    function automatic logic [31:0] period_for(input logic [2:0] idx,
                                               input logic [31:0] slow,
                                               input logic [31:0] step);
        return slow - ({29'd0, idx} * step);
    endfunction

endpackage

// File: rtl/button_debounce.sv
// One board button: two-flop synchronizer, stability counter and a one-cycle
// pulse when a press (0->1 of the accepted level) is accepted.
module button_debounce
    import led_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_a;
    logic          sync_b;
    logic          level;
    logic [CW-1:0] count;

    // Bring the asynchronous button level into the clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
        end
    end

    // Accept a new level only after it has disagreed with the old one long enough; flag presses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= 1'b0;
            count <= '0;
            press <= 1'b0;
        end else if (sync_b != level) begin
            if (count == LAST_COUNT) begin
                level <= sync_b;
                count <= '0;
                press <= sync_b;
            end else begin
                count <= count + 1'b1;
                press <= 1'b0;
            end
        end else begin
            count <= '0;
            press <= 1'b0;
        end
    end

endmodule

// File: rtl/led_step_ctrl.sv
// Front-panel controller: turns debounced button presses into speed, pause,
// run and single-step commands and emits the step_pulse enable for the LED ring.
module led_step_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned PERIOD_SLOW     = 5000000,
    parameter int unsigned PERIOD_STEP     = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  buttons,
    output logic        step_pulse,
    output logic [2:0]  speed_idx,
    output logic [31:0] period,
    output logic        running
);

    // The fastest period must stay at least one cycle long.
    if (!(64'(PERIOD_SLOW) > 64'(MAX_IDX) * 64'(PERIOD_STEP))) begin : g_bad_periods
        $error("led_step_ctrl: PERIOD_SLOW must exceed 4*PERIOD_STEP");
    end

    logic [4:0]  press;
    cmd_t        cmd;
    logic [2:0]  speed_next;
    logic        speed_change;
    logic [31:0] period_next;
    logic [31:0] tick;
    step_state_t state;

    for (genvar i = 0; i < 5; i++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk  (clk),
            .rst  (rst),
            .raw  (buttons[i]),
            .press(press[i])
        );
    end

    // Keep only the highest-priority press of this cycle.
    always_comb begin
        cmd = CMD_NONE;
        if (press[BTN_DEFAULT])
            cmd = CMD_DEFAULT;
        else if (press[BTN_PAUSE])
            cmd = CMD_PAUSE;
        else if (press[BTN_SINGLE])
            cmd = CMD_SINGLE;
        else if (press[BTN_FASTER])
            cmd = CMD_FASTER;
        else if (press[BTN_SLOWER])
            cmd = CMD_SLOWER;
    end

    // Work out the next speed level; saturated presses leave it unchanged.
    always_comb begin
        speed_next = speed_idx;
        case (cmd)
            CMD_DEFAULT: speed_next = 3'd0;
            CMD_FASTER:  if (speed_idx < MAX_IDX) speed_next = speed_idx + 3'd1;
            CMD_SLOWER:  if (speed_idx != 3'd0) speed_next = speed_idx - 3'd1;
            default:     speed_next = speed_idx;
        endcase
        speed_change = (speed_next != speed_idx);
        period_next  = period_for(speed_next, PERIOD_SLOW, PERIOD_STEP);
    end

    // Run/pause/step sequencing with the tick counter and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            tick       <= '0;
            step_pulse <= 1'b0;
            speed_idx  <= 3'd0;
            period     <= PERIOD_SLOW;
            running    <= 1'b1;
        end else begin
            speed_idx  <= speed_next;
            period     <= period_next;
            step_pulse <= 1'b0;
            case (state)
                RUN: begin
                    if (cmd == CMD_PAUSE) begin
                        state   <= PAUSE;
                        running <= 1'b0;
                        tick    <= '0;
                    end else if (speed_change) begin
                        tick <= '0;
                    end else if (tick == period - 32'd1) begin
                        tick       <= '0;
                        step_pulse <= 1'b1;
                    end else begin
                        tick <= tick + 32'd1;
                    end
                end
                PAUSE: begin
                    tick <= '0;
                    if (cmd == CMD_PAUSE) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end else if (cmd == CMD_SINGLE) begin
                        state      <= STEP;
                        step_pulse <= 1'b1;
                    end
                end
                STEP: begin
                    tick  <= '0;
                    state <= PAUSE;
                end
                default: begin
                    state   <= RUN;
                    running <= 1'b1;
                    tick    <= '0;
                end
            endcase
        end
    end

endmodule
